cpu: RTL and testbench
======================

Name: cpu

Overview:
- Single-cycle, 8-bit accumulator processor datapath.
- Each clock edge executes the 3-bit opcode on the accumulator and the value on the input data bus; the accumulator value is driven continuously on out_acc.
- Internally split into three parts:
  - instruction decoder (opcode to ALU/write-enable controls)
  - combinational ALU
  - accumulator register
- Top-level compute core fed by an external instruction/data source.

Parameters:
- DATA_WIDTH, 8, width of data bus, ALU and accumulator. All requirements below use DATA_WIDTH=8.

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- opcode  input  3  instruction executed at the next rising edge
- Data_bus_in  input  8  operand or load value for the current instruction
- out_acc  output  8  current accumulator contents (registered, no combinational path from inputs)

Behaviour:
- One clock (clock); reset is synchronous and active-high. Reset is sampled only on the rising edge of clock.
- Reset:
  - Rising edge with reset=1 sets acc to 8'h00; out_acc=8'h00 from that edge on.
  - Reset has priority over any opcode.
  - Reset asserted mid-stream clears acc on that edge regardless of opcode and data.
- Execution:
  - Every rising edge with reset=0 executes exactly one instruction; no fetch, stall or handshake.
  - Latency is 1 cycle: inputs sampled at edge N, result visible on out_acc right after edge N.
- Opcode map (acc_next, with D = Data_bus_in):
  - 000 ADD: acc + D, modulo 256 (carry discarded, wraps)
  - 001 LOAD: D
  - 010 STORE: acc unchanged (accumulator is not written; D ignored)
  - 011 SUB: acc - D, modulo 256 (borrow discarded, wraps)
  - 100 AND: acc & D
  - 101 OR: acc | D
  - 110 XOR: acc ^ D
  - 111 NOP: acc unchanged
- Write enable:
  - The decoder asserts accumulator write-enable for 000, 001, 011, 100, 101 and 110.
  - It deasserts write-enable for 010 and 111.
- Arithmetic is unsigned 8-bit; no flags exported.
- X or undefined opcode values need not be handled beyond the map above. All 8 codes are defined, so no illegal-opcode state exists.
- out_acc:
  - Driven directly from the accumulator register.
  - Changing opcode or Data_bus_in between edges must not change out_acc.

Test Plan:
- Reset then ADD: reset=1 for one edge gives out_acc=00000000. Then reset=0, opcode=000, D=00001010, one edge gives out_acc=00001010.
- LOAD then STORE:
  - From acc=00001010, opcode=001, D=00001111, one edge gives out_acc=00001111.
  - Then opcode=010, D=00000000, one edge gives out_acc still 00001111.
- Wrap-around:
  - LOAD 8'hF0, then ADD 8'h20 gives 8'h10.
  - LOAD 8'h05, then SUB 8'h06 gives 8'hFF.
- Logic ops:
  - LOAD 8'hCC, then AND 8'hAA gives 8'h88.
  - OR 8'h11 gives 8'h99.
  - XOR 8'hFF gives 8'h66.
- NOP and hold:
  - With acc=8'h66, apply opcode=111 and random D for 3 edges; out_acc stays 8'h66.
  - Toggling inputs between edges causes no change on out_acc.
- Reset mid-operation: acc=8'h66, reset=1 with opcode=001, D=8'h7E at the edge gives out_acc=8'h00. With reset still held over further ADD edges, acc stays 8'h00.

Source files
------------

// File: rtl/cpu.sv
// Single-cycle 8-bit accumulator datapath: opcode decoder, combinational ALU
// and accumulator register. One instruction executes on every rising edge.
module cpu #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [2:0]            opcode,
  input  logic [DATA_WIDTH-1:0] Data_bus_in,
  output logic [DATA_WIDTH-1:0] out_acc
);

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_LOAD  = 3'b001,
    OP_STORE = 3'b010,
    OP_SUB   = 3'b011,
    OP_AND   = 3'b100,
    OP_OR    = 3'b101,
    OP_XOR   = 3'b110,
    OP_NOP   = 3'b111
  } op_e;

  op_e                   op;
  logic                  acc_we;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] alu_result;

  assign op = op_e'(opcode);

  // Decoder: STORE and NOP leave the accumulator untouched.
  always_comb begin
    acc_we = 1'b0;
    case (op)
      OP_ADD, OP_LOAD, OP_SUB, OP_AND, OP_OR, OP_XOR: acc_we = 1'b1;
      default:                                         acc_we = 1'b0;
    endcase
  end

  // ALU: unsigned arithmetic wraps modulo 2**DATA_WIDTH.
  always_comb begin
    alu_result = acc;
    case (op)
      OP_ADD:  alu_result = acc + Data_bus_in;
      OP_LOAD: alu_result = Data_bus_in;
      OP_SUB:  alu_result = acc - Data_bus_in;
      OP_AND:  alu_result = acc & Data_bus_in;
      OP_OR:   alu_result = acc | Data_bus_in;
      OP_XOR:  alu_result = acc ^ Data_bus_in;
      default: alu_result = acc;
    endcase
  end

  // Accumulator register; reset takes priority over any opcode.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc <= '0;
    end else if (acc_we) begin
      acc <= alu_result;
    end
  end

  assign out_acc = acc;

endmodule

// File: tb/tb_cpu.sv
// Directed self-checking bench for the accumulator datapath.
module tb_cpu;

  logic       clock;
  logic       reset;
  logic [2:0] opcode;
  logic [7:0] Data_bus_in;
  logic [7:0] out_acc;

  int checks = 0;
  int errors = 0;

  cpu #(.DATA_WIDTH(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .opcode     (opcode),
    .Data_bus_in(Data_bus_in),
    .out_acc    (out_acc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Apply inputs, take one rising edge, then settle 1 time unit.
  task automatic step(input logic rst, input logic [2:0] op, input logic [7:0] d);
    reset       = rst;
    opcode      = op;
    Data_bus_in = d;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    step(1'b1, 3'b000, 8'hA5);
    checks++;
    if (out_acc !== 8'h00) begin
      errors++;
      $display("FAIL reset: got %h expected %h", out_acc, 8'h00);
    end
  endtask

  task automatic test_add;
    step(1'b0, 3'b000, 8'b00001010);
    checks++;
    if (out_acc !== 8'h0A) begin
      errors++;
      $display("FAIL add: got %h expected %h", out_acc, 8'h0A);
    end
  endtask

  task automatic test_load_store;
    step(1'b0, 3'b001, 8'b00001111);
    checks++;
    if (out_acc !== 8'h0F) begin
      errors++;
      $display("FAIL load: got %h expected %h", out_acc, 8'h0F);
    end
    step(1'b0, 3'b010, 8'h00);
    checks++;
    if (out_acc !== 8'h0F) begin
      errors++;
      $display("FAIL store_hold: got %h expected %h", out_acc, 8'h0F);
    end
    step(1'b0, 3'b010, 8'hFF);
    checks++;
    if (out_acc !== 8'h0F) begin
      errors++;
      $display("FAIL store_hold_ff: got %h expected %h", out_acc, 8'h0F);
    end
  endtask

  task automatic test_wrap;
    step(1'b0, 3'b001, 8'hF0);
    step(1'b0, 3'b000, 8'h20);
    checks++;
    if (out_acc !== 8'h10) begin
      errors++;
      $display("FAIL add_wrap: got %h expected %h", out_acc, 8'h10);
    end
    step(1'b0, 3'b001, 8'h05);
    step(1'b0, 3'b011, 8'h06);
    checks++;
    if (out_acc !== 8'hFF) begin
      errors++;
      $display("FAIL sub_wrap: got %h expected %h", out_acc, 8'hFF);
    end
    step(1'b0, 3'b011, 8'h0F);
    checks++;
    if (out_acc !== 8'hF0) begin
      errors++;
      $display("FAIL sub_plain: got %h expected %h", out_acc, 8'hF0);
    end
  endtask

  task automatic test_logic;
    step(1'b0, 3'b001, 8'hCC);
    step(1'b0, 3'b100, 8'hAA);
    checks++;
    if (out_acc !== 8'h88) begin
      errors++;
      $display("FAIL and: got %h expected %h", out_acc, 8'h88);
    end
    step(1'b0, 3'b101, 8'h11);
    checks++;
    if (out_acc !== 8'h99) begin
      errors++;
      $display("FAIL or: got %h expected %h", out_acc, 8'h99);
    end
    step(1'b0, 3'b110, 8'hFF);
    checks++;
    if (out_acc !== 8'h66) begin
      errors++;
      $display("FAIL xor: got %h expected %h", out_acc, 8'h66);
    end
  endtask

  task automatic test_nop_hold;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 3'b111, 8'($urandom));
      checks++;
      if (out_acc !== 8'h66) begin
        errors++;
        $display("FAIL nop_hold[%0d]: got %h expected %h", i, out_acc, 8'h66);
      end
    end
    // Wiggle inputs between edges; the output must stay registered.
    for (int i = 0; i < 4; i++) begin
      opcode      = 3'(i * 3);
      Data_bus_in = 8'(8'h3C + i * 8'h21);
      #1;
      checks++;
      if (out_acc !== 8'h66) begin
        errors++;
        $display("FAIL toggle_hold[%0d]: got %h expected %h", i, out_acc, 8'h66);
      end
    end
  endtask

  task automatic test_reset_mid;
    step(1'b1, 3'b001, 8'h7E);
    checks++;
    if (out_acc !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid: got %h expected %h", out_acc, 8'h00);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 3'b000, 8'h55);
      checks++;
      if (out_acc !== 8'h00) begin
        errors++;
        $display("FAIL reset_held[%0d]: got %h expected %h", i, out_acc, 8'h00);
      end
    end
  endtask

  task automatic test_back_to_back;
    // Running sequence: 00 +3 =03, -1 =02, ^0F =0D, |30 =3D, &F1 =31, +FF =30
    step(1'b0, 3'b000, 8'h03);
    checks++;
    if (out_acc !== 8'h03) begin
      errors++;
      $display("FAIL b2b_add: got %h expected %h", out_acc, 8'h03);
    end
    step(1'b0, 3'b011, 8'h01);
    checks++;
    if (out_acc !== 8'h02) begin
      errors++;
      $display("FAIL b2b_sub: got %h expected %h", out_acc, 8'h02);
    end
    step(1'b0, 3'b110, 8'h0F);
    checks++;
    if (out_acc !== 8'h0D) begin
      errors++;
      $display("FAIL b2b_xor: got %h expected %h", out_acc, 8'h0D);
    end
    step(1'b0, 3'b101, 8'h30);
    checks++;
    if (out_acc !== 8'h3D) begin
      errors++;
      $display("FAIL b2b_or: got %h expected %h", out_acc, 8'h3D);
    end
    step(1'b0, 3'b100, 8'hF1);
    checks++;
    if (out_acc !== 8'h31) begin
      errors++;
      $display("FAIL b2b_and: got %h expected %h", out_acc, 8'h31);
    end
    step(1'b0, 3'b000, 8'hFF);
    checks++;
    if (out_acc !== 8'h30) begin
      errors++;
      $display("FAIL b2b_add_wrap: got %h expected %h", out_acc, 8'h30);
    end
  endtask

  initial begin
    reset       = 1'b1;
    opcode      = 3'b000;
    Data_bus_in = 8'h00;
    test_reset();
    test_add();
    test_load_store();
    test_wrap();
    test_logic();
    test_nop_hold();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
